rgb_pixel_fetch: RTL and testbench
==================================

Name: rgb_pixel_fetch

Overview:
- Source end of the RGB2G pixel interface; replaces the bench-side memory indexing.
- Reads an interleaved R,G,B byte image from a byte-wide synchronous memory, one byte per cycle.
- Assembles each pixel and presents it on data_0/data_1/data_2 with its pixel index under a valid/ready handshake.
- Asserts done after the last pixel is accepted; feeds the RGB2G converter.

Parameters:
ROW, 2048, image rows
COL, 1153, image columns
ADDR_W, 23, byte address width; must satisfy 2^ADDR_W >= ROW*COL*3
PIX_W, 22, pixel index width; must satisfy 2^PIX_W >= ROW*COL

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
start  in  1  one-cycle pulse; begins a frame when idle or done
mem_rd  out  1  byte read strobe
mem_addr  out  ADDR_W  byte address, valid when mem_rd=1
mem_rdata  in  8  read data, returned exactly 1 cycle after mem_rd
data_0  out  8  R byte (address 3p)
data_1  out  8  G byte (address 3p+1)
data_2  out  8  B byte (address 3p+2)
pixel  out  PIX_W  index p of the presented pixel
out_valid  out  1  pixel presented
out_ready  in  1  consumer accepts; transfer when out_valid && out_ready
done  out  1  frame complete, level

Behaviour:
- Reset: all outputs 0, counters 0, state IDLE, in-flight reads discarded. Applies mid-frame; returned mem_rdata after reset is ignored.
- States:
  - IDLE: waits for start, then moves to FETCH.
  - FETCH: issues reads and waits for the last pixel's transfer, then moves to DONE.
  - DONE: done=1; start clears done, resets counters, and moves to FETCH.
- start is ignored in FETCH.
- Read issue:
  - Lane counter cycles 0,1,2; mem_addr = 3*rd_pix + lane.
  - Address increments by 1 per issued read and never wraps.
  - No reads after address ROW*COL*3-1.
- Capture:
  - Data for lanes 0 and 1 goes into the assembly register.
  - Lane-2 data loads the output register directly if it is empty or being drained in that cycle.
  - Otherwise lane-2 data goes to assembly lane 2 and sets asm_full.
  - A full assembly moves to the output register on the first cycle the output frees; that cycle clears asm_full.
- Read stall rules:
  - No read is issued while asm_full=1.
  - A lane-0 read is not issued in a cycle where a lane-2 read is in flight and out_valid=1.
  - These rules guarantee no capture slot is overwritten.
- Latency and throughput:
  - First out_valid arrives 4 cycles after the cycle start is sampled.
  - Steady state with out_ready held at 1 is 1 pixel per 3 cycles, out_valid high 1 cycle in 3.
- Handshake:
  - While out_valid=1 and out_ready=0, data_0..2 and pixel hold stable.
  - out_valid never drops without a transfer.
  - pixel increments by 1 per transfer.
- Completion: done rises the cycle after the transfer of pixel ROW*COL-1. Reads have already stopped and out_valid=0.
- Simultaneous events:
  - A lane-2 capture and an output transfer in the same cycle go straight into the output register.
  - rst overrides start.

Decomposition:
- Shared package rgb_pkg holds:
  - the ROW/COL defaults and the derived NPIX = ROW*COL and NBYTE = NPIX*3;
  - a pixel struct {r,g,b} of 3 x 8-bit;
  - the FSM state enum (IDLE, FETCH, DONE).
- One natural sub-module, rgb_pixel_skid: the assembly register plus output register with the valid/ready and asm_full logic.
- The parent keeps the FSM, address/lane counters and read-issue rules.

Test Plan:
1. ROW=2, COL=2, memory bytes 0x00..0x0B, out_ready=1, start pulse -> 4 pixels:
   - p0 = (00,01,02), p3 = (09,0A,0B);
   - mem_addr sequence 0..11, then no further mem_rd;
   - out_valid every 3rd cycle;
   - done=1 one cycle after p3 is accepted.
2. Same image, out_ready=0 for 10 cycles after the first out_valid:
   - data_0..2 = 00,01,02 and pixel=0 are held;
   - reads stop at address 5 with asm_full=1;
   - after release, p1 = (03,04,05) is presented the next cycle and no byte is lost.
3. Random out_ready (50%) over a ROW=4, COL=3 image -> a scoreboard matches all 12 pixels in order with a contiguous pixel index.
4. rst asserted during FETCH at pixel 1:
   - next cycle all outputs are 0 and the state is IDLE;
   - a new start restarts at mem_addr 0 and pixel 0.
5. start pulsed during FETCH is ignored. start in DONE clears done and refetches p0 = (00,01,02).
6. rst and start in the same cycle -> rst wins and the block stays IDLE.

Source files
------------

// File: rtl/rgb_pkg.sv
// Shared types and image-size defaults for the RGB pixel fetch path.
package rgb_pkg;

    localparam int ROW_DEF = 2048;
    localparam int COL_DEF = 1153;
    localparam int NPIX    = ROW_DEF * COL_DEF;
    localparam int NBYTE   = NPIX * 3;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/rgb_pixel_fetch_if.sv
// Memory read port plus pixel output stream of the RGB pixel fetcher.
interface rgb_pixel_fetch_if #(
    parameter int ADDR_W = 23,
    parameter int PIX_W  = 22
);
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic [7:0]        data_0;
    logic [7:0]        data_1;
    logic [7:0]        data_2;
    logic [PIX_W-1:0]  pixel;
    logic              out_valid;
    logic              out_ready;

    // A pixel moves when out_valid && out_ready at a rising edge; once raised,
    // out_valid and its data/pixel hold until that transfer happens.
    modport master (
        output mem_rd, mem_addr,
        input  mem_rdata,
        output data_0, data_1, data_2, pixel, out_valid,
        input  out_ready
    );

    modport slave (
        input  mem_rd, mem_addr,
        output mem_rdata,
        input  data_0, data_1, data_2, pixel, out_valid,
        output out_ready
    );
endinterface

// File: rtl/rgb_pixel_skid.sv
// Pixel assembly register plus output register with valid/ready and index counter.
module rgb_pixel_skid
    import rgb_pkg::*;
#(
    parameter int PIX_W = 22
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             cap_vld,
    input  logic [1:0]       cap_lane,
    input  logic [7:0]       cap_data,
    input  logic             out_ready,
    output logic             out_valid,
    output pixel_t           out_pix,
    output logic [PIX_W-1:0] pixel,
    output logic             asm_full,
    output logic             xfer
);
    pixel_t asm_pix;
    logic   out_free;
    logic   cap2;
    logic   direct;
    logic   to_asm;
    logic   move;

    assign xfer     = out_valid && out_ready;
    assign out_free = !out_valid || out_ready;
    assign cap2     = cap_vld && (cap_lane == 2'd2);
    assign direct   = cap2 && out_free;
    assign to_asm   = cap2 && !out_free;
    // Read stalls keep lane-2 captures away from cycles where asm_full is set.
    assign move     = asm_full && out_free;

    always_ff @(posedge clk) begin
        if (rst) begin
            asm_pix   <= '0;
            asm_full  <= 1'b0;
            out_pix   <= '0;
            out_valid <= 1'b0;
            pixel     <= '0;
        end else begin
            if (cap_vld && cap_lane == 2'd0) asm_pix.r <= cap_data;
            if (cap_vld && cap_lane == 2'd1) asm_pix.g <= cap_data;
            if (to_asm) asm_pix.b <= cap_data;

            if (direct) begin
                out_pix   <= '{r: asm_pix.r, g: asm_pix.g, b: cap_data};
                out_valid <= 1'b1;
            end else if (move) begin
                out_pix   <= asm_pix;
                out_valid <= 1'b1;
            end else if (xfer) begin
                out_valid <= 1'b0;
            end

            if (to_asm) asm_full <= 1'b1;
            else if (move) asm_full <= 1'b0;

            if (clr) pixel <= '0;
            else if (xfer) pixel <= pixel + PIX_W'(1);
        end
    end
endmodule

// File: rtl/rgb_pixel_fetch.sv
// Reads an interleaved R,G,B byte image and streams assembled pixels with their index.
module rgb_pixel_fetch
    import rgb_pkg::*;
#(
    parameter int ROW    = ROW_DEF,
    parameter int COL    = COL_DEF,
    parameter int ADDR_W = 23,
    parameter int PIX_W  = 22
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    rgb_pixel_fetch_if.master bus,
    output logic              done,
    output state_e            dbg_state,
    output logic              dbg_asm_full
);
    localparam int N_PIX  = ROW * COL;
    localparam int N_BYTE = N_PIX * 3;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_BYTE - 1);
    localparam logic [PIX_W-1:0]  LAST_PIX  = PIX_W'(N_PIX - 1);

    state_e            state;
    logic [ADDR_W-1:0] rd_addr;
    logic [1:0]        lane;
    logic [1:0]        rd_lane_q;
    logic              rd_done;
    logic              rd_vld_q;
    logic              asm_full;
    logic              out_valid;
    logic              xfer;
    logic              lane0_hold;
    logic              issue;
    logic              restart;
    logic [PIX_W-1:0]  pix;
    pixel_t            out_pix;

    // A lane-0 read now would land in asm lane 0 while a stalled lane-2 byte may park there.
    assign lane0_hold = (lane == 2'd0) && rd_vld_q && (rd_lane_q == 2'd2) && out_valid;
    assign issue      = (state == ST_FETCH) && !rd_done && !asm_full && !lane0_hold;
    assign restart    = (state == ST_DONE) && start;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            rd_addr   <= '0;
            lane      <= 2'd0;
            rd_done   <= 1'b0;
            rd_vld_q  <= 1'b0;
            rd_lane_q <= 2'd0;
            done      <= 1'b0;
        end else begin
            rd_vld_q  <= issue;
            rd_lane_q <= lane;
            case (state)
                ST_IDLE: begin
                    if (start) state <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (issue) begin
                        lane <= (lane == 2'd2) ? 2'd0 : lane + 2'd1;
                        if (rd_addr == LAST_ADDR) rd_done <= 1'b1;
                        else rd_addr <= rd_addr + ADDR_W'(1);
                    end
                    if (xfer && pix == LAST_PIX) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        state   <= ST_FETCH;
                        done    <= 1'b0;
                        rd_addr <= '0;
                        lane    <= 2'd0;
                        rd_done <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    rgb_pixel_skid #(.PIX_W(PIX_W)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .clr       (restart),
        .cap_vld   (rd_vld_q),
        .cap_lane  (rd_lane_q),
        .cap_data  (bus.mem_rdata),
        .out_ready (bus.out_ready),
        .out_valid (out_valid),
        .out_pix   (out_pix),
        .pixel     (pix),
        .asm_full  (asm_full),
        .xfer      (xfer)
    );

    assign bus.mem_rd    = issue;
    assign bus.mem_addr  = rd_addr;
    assign bus.data_0    = out_pix.r;
    assign bus.data_1    = out_pix.g;
    assign bus.data_2    = out_pix.b;
    assign bus.pixel     = pix;
    assign bus.out_valid = out_valid;
    assign dbg_state     = state;
    assign dbg_asm_full  = asm_full;
endmodule

// File: tb/tb_rgb_pixel_fetch.sv
// Bench for rgb_pixel_fetch: a 2x2 instance for directed cases and a 4x3 instance for random backpressure.
module tb_rgb_pixel_fetch;
    import rgb_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic   rst = 1'b1;
    logic   start_a = 1'b0;
    logic   start_b = 1'b0;
    logic   done_a, done_b, af_a, af_b;
    state_e st_a, st_b;

    rgb_pixel_fetch_if #(.ADDR_W(4), .PIX_W(4)) if_a ();
    rgb_pixel_fetch_if #(.ADDR_W(6), .PIX_W(4)) if_b ();

    rgb_pixel_fetch #(.ROW(2), .COL(2), .ADDR_W(4), .PIX_W(4)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .bus(if_a),
        .done(done_a), .dbg_state(st_a), .dbg_asm_full(af_a)
    );
    rgb_pixel_fetch #(.ROW(4), .COL(3), .ADDR_W(6), .PIX_W(4)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .bus(if_b),
        .done(done_b), .dbg_state(st_b), .dbg_asm_full(af_b)
    );

    // ---------------- memory model: data one cycle after the strobe ----------------
    logic [7:0] mem_a [16];
    logic [7:0] mem_b [64];
    always @(posedge clk) begin
        if (if_a.mem_rd) if_a.mem_rdata <= mem_a[if_a.mem_addr];
        if (if_b.mem_rd) if_b.mem_rdata <= mem_b[if_b.mem_addr];
    end

    // ---------------- checker ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard: {pixel, r, g, b} in image order ----------------
    logic [27:0] exp_q_a[$];
    logic [27:0] exp_q_b[$];
    int          exp_addr_a = 0;
    int          exp_addr_b = 0;
    logic        hold_a = 1'b0;
    logic        hold_b = 1'b0;
    logic [27:0] held_a, held_b;

    task automatic load_exp_a();
        exp_q_a.delete();
        for (int p = 0; p < 4; p++)
            exp_q_a.push_back({4'(p), mem_a[3*p], mem_a[3*p+1], mem_a[3*p+2]});
        exp_addr_a = 0;
    endtask

    task automatic load_exp_b();
        exp_q_b.delete();
        for (int p = 0; p < 12; p++)
            exp_q_b.push_back({4'(p), mem_b[3*p], mem_b[3*p+1], mem_b[3*p+2]});
        exp_addr_b = 0;
    endtask

    always @(negedge clk) begin : mon_a
        logic [27:0] cur;
        cur = {if_a.pixel, if_a.data_0, if_a.data_1, if_a.data_2};
        if (rst) begin
            hold_a = 1'b0;
        end else begin
            if (hold_a) begin
                check("hold_valid_a", if_a.out_valid, 1'b1);
                check("hold_data_a", cur, held_a);
            end
            if (if_a.mem_rd) begin
                check("rd_addr_a", if_a.mem_addr, exp_addr_a);
                check("rd_range_a", exp_addr_a < 12, 1'b1);
                exp_addr_a++;
            end
            if (if_a.out_valid && if_a.out_ready) begin
                if (exp_q_a.size() == 0) check("sb_underflow_a", exp_q_a.size(), 1);
                else check("pix_a", cur, exp_q_a.pop_front());
            end
            hold_a = if_a.out_valid && !if_a.out_ready;
            held_a = cur;
        end
    end

    always @(negedge clk) begin : mon_b
        logic [27:0] cur;
        cur = {if_b.pixel, if_b.data_0, if_b.data_1, if_b.data_2};
        if (rst) begin
            hold_b = 1'b0;
        end else begin
            if (hold_b) begin
                check("hold_valid_b", if_b.out_valid, 1'b1);
                check("hold_data_b", cur, held_b);
            end
            if (if_b.mem_rd) begin
                check("rd_addr_b", if_b.mem_addr, exp_addr_b);
                check("rd_range_b", exp_addr_b < 36, 1'b1);
                exp_addr_b++;
            end
            if (if_b.out_valid && if_b.out_ready) begin
                if (exp_q_b.size() == 0) check("sb_underflow_b", exp_q_b.size(), 1);
                else check("pix_b", cur, exp_q_b.pop_front());
            end
            hold_b = if_b.out_valid && !if_b.out_ready;
            held_b = cur;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic pulse_a();
        start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
    endtask

    task automatic pulse_b();
        start_b = 1'b1;
        tick(1);
        start_b = 1'b0;
    endtask

    task automatic wait_done_a(input string tag, input int budget);
        for (int k = 0; k < budget && !done_a; k++) tick(1);
        check(tag, done_a, 1'b1);
    endtask

    task automatic wait_valid_a(input string tag, input int budget);
        for (int k = 0; k < budget && !if_a.out_valid; k++) tick(1);
        check(tag, if_a.out_valid, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 16; i++) mem_a[i] = 8'(i);
        for (int i = 0; i < 64; i++) mem_b[i] = 8'($urandom_range(0, 255));
        if_a.out_ready = 1'b0;
        if_b.out_ready = 1'b0;

        // reset state
        do_reset();
        check("rst_outs_a", {if_a.mem_rd, if_a.mem_addr, if_a.data_0, if_a.data_1, if_a.data_2,
                             if_a.pixel, if_a.out_valid, done_a, af_a}, '0);
        check("rst_state_a", st_a, ST_IDLE);
        check("rst_outs_b", {if_b.mem_rd, if_b.mem_addr, if_b.pixel, if_b.out_valid, done_b}, '0);

        // 1: full-rate frame, latency, cadence, done timing
        if_a.out_ready = 1'b1;
        load_exp_a();
        pulse_a();
        for (int k = 1; k <= 14; k++) begin
            tick(1);
            check("t1_valid", if_a.out_valid, (k >= 4) && (k <= 13) && ((k - 4) % 3 == 0));
            check("t1_done", done_a, k >= 14);
        end
        tick(3);
        check("t1_nreads", exp_addr_a, 12);
        check("t1_sb_empty", exp_q_a.size(), 0);
        check("t1_state", st_a, ST_DONE);

        // 2: backpressure on the first pixel
        do_reset();
        if_a.out_ready = 1'b0;
        load_exp_a();
        pulse_a();
        wait_valid_a("t2_first_valid", 20);
        tick(10);
        check("t2_hold", {if_a.pixel, if_a.data_0, if_a.data_1, if_a.data_2}, {4'd0, 24'h000102});
        check("t2_asm_full", af_a, 1'b1);
        check("t2_reads", exp_addr_a, 6);
        if_a.out_ready = 1'b1;
        tick(1);
        check("t2_p1_valid", if_a.out_valid, 1'b1);
        check("t2_p1", {if_a.pixel, if_a.data_0, if_a.data_1, if_a.data_2}, {4'd1, 24'h030405});
        wait_done_a("t2_done", 60);
        check("t2_sb_empty", exp_q_a.size(), 0);

        // 3: random backpressure on the 4x3 image
        do_reset();
        load_exp_b();
        if_b.out_ready = 1'($urandom_range(0, 1));
        pulse_b();
        for (int k = 0; k < 800 && !done_b; k++) begin
            if_b.out_ready = 1'($urandom_range(0, 1));
            tick(1);
        end
        check("t3_done", done_b, 1'b1);
        check("t3_sb_empty", exp_q_b.size(), 0);
        check("t3_nreads", exp_addr_b, 36);
        if_b.out_ready = 1'b0;

        // 4: reset while pixel 1 is presented
        do_reset();
        if_a.out_ready = 1'b1;
        load_exp_a();
        pulse_a();
        for (int k = 0; k < 40 && !(if_a.out_valid && if_a.pixel == 4'd1); k++) tick(1);
        check("t4_at_p1", {if_a.out_valid, if_a.pixel}, {1'b1, 4'd1});
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("t4_outs", {if_a.mem_rd, if_a.mem_addr, if_a.data_0, if_a.data_1, if_a.data_2,
                          if_a.pixel, if_a.out_valid, done_a, af_a}, '0);
        check("t4_state", st_a, ST_IDLE);
        tick(2);
        check("t4_still_idle", {st_a, if_a.mem_rd, if_a.out_valid}, {ST_IDLE, 2'b00});
        load_exp_a();
        pulse_a();
        wait_done_a("t4_done", 60);
        check("t4_sb_empty", exp_q_a.size(), 0);

        // 5: start ignored in FETCH, honoured in DONE
        do_reset();
        load_exp_a();
        pulse_a();
        tick(5);
        pulse_a();
        check("t5_fetch", st_a, ST_FETCH);
        wait_done_a("t5_done1", 60);
        check("t5_sb1_empty", exp_q_a.size(), 0);
        tick(3);
        check("t5_done_level", {done_a, st_a}, {1'b1, ST_DONE});
        load_exp_a();
        pulse_a();
        check("t5_done_clr", {done_a, st_a}, {1'b0, ST_FETCH});
        wait_done_a("t5_done2", 60);
        check("t5_sb2_empty", exp_q_a.size(), 0);

        // 6: rst and start together
        rst = 1'b1;
        start_a = 1'b1;
        tick(1);
        rst = 1'b0;
        start_a = 1'b0;
        check("t6_state", st_a, ST_IDLE);
        tick(4);
        check("t6_idle", {st_a, if_a.mem_rd, if_a.out_valid, done_a}, {ST_IDLE, 3'b000});

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
